// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and UART framing constants for the TX arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Arbiter FSM: idle/arbitrating, issuing the start pulse, waiting for done
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } uart_arb_state_t;

    localparam int UART_CLOCKS_PER_BAUD = 33;
    localparam int UART_FRAME_BITS      = 10;
    // Watchdog default: four full frames of slack before giving up on done
    localparam int UART_TX_TIMEOUT      = 4 * UART_FRAME_BITS * UART_CLOCKS_PER_BAUD;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester and UART-side signal bundle of the TX arbiter.
//               master = requesters + UART, slave = arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int c_IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid_in;
    logic [8*NUM_REQ-1:0] req_data_in;
    logic [NUM_REQ-1:0]   req_ready_out;
    logic [7:0]           tx_data_out;
    logic                 tx_start_out;
    logic                 tx_done_in;
    logic                 busy_out;
    logic [c_IDX_W-1:0]   grant_id_out;
    logic                 timeout_out;

    modport master (
        output req_valid_in, req_data_in, tx_done_in,
        input  req_ready_out, tx_data_out, tx_start_out, busy_out,
               grant_id_out, timeout_out
    );

    modport slave (
        input  req_valid_in, req_data_in, tx_done_in,
        output req_ready_out, tx_data_out, tx_start_out, busy_out,
               grant_id_out, timeout_out
    );

endinterface : uart_tx_arbiter_if
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin selector. Searches upward with wrap
//               starting one past the previous grantee.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] i_valid,
    input  wire logic [IDX_W-1:0]   i_last_grant,
    output logic      [NUM_REQ-1:0] o_grant_onehot,
    output logic      [IDX_W-1:0]   o_grant_idx,
    output logic                    o_any
);
    localparam logic [IDX_W:0] c_SHIFT_ONE = {{IDX_W{1'b0}}, 1'b1};

    // Rotation amount is last_grant+1, one bit wider so NUM_REQ itself fits
    logic [IDX_W:0]     w_shift;
    logic [2*NUM_REQ-1:0] w_rot_dbl;
    logic [NUM_REQ-1:0] w_rot;
    logic [NUM_REQ-1:0] w_low;
    logic [2*NUM_REQ-1:0] w_back_dbl;

    assign w_shift    = {1'b0, i_last_grant} + c_SHIFT_ONE;
    // Rotate so the first candidate sits at bit 0; works for any NUM_REQ
    assign w_rot_dbl  = {i_valid, i_valid} >> w_shift;
    assign w_rot      = w_rot_dbl[NUM_REQ-1:0];
    // Lowest set bit of the rotated vector is the winner
    assign w_low      = w_rot & (-w_rot);
    // Undo the rotation to get the winner in requester numbering
    assign w_back_dbl = {w_low, w_low} << w_shift;

    assign o_grant_onehot = w_back_dbl[2*NUM_REQ-1:NUM_REQ];
    assign o_any          = |i_valid;

    // Binary-encode the one-hot winner
    always_comb begin
        o_grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (o_grant_onehot[i]) begin
                o_grant_idx = IDX_W'(i);
            end
        end
    end

endmodule : rr_picker
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin, per-byte arbiter sharing one uart_tx between
//               NUM_REQ producers, with a done watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = UART_TX_TIMEOUT
) (
    input wire logic         clk_in,
    input wire logic         rst_n_in,
    uart_tx_arbiter_if.slave bus
);
    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = {{(c_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NUM_REQ - 1);

    uart_arb_state_t     r_state;
    logic [c_IDX_W-1:0]  r_last_grant;
    logic [c_IDX_W-1:0]  r_grant_id;
    logic [7:0]          r_tx_data;
    logic                r_tx_start;
    logic                r_busy;
    logic [c_CNT_W-1:0]  r_wdog;

    logic [NUM_REQ-1:0]  w_pick_onehot;
    logic [c_IDX_W-1:0]  w_pick_idx;
    logic                w_pick_any;
    logic [7:0]          w_pick_data;
    logic                w_grant;
    logic                w_timeout;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_picker (
        .i_valid        (bus.req_valid_in),
        .i_last_grant   (r_last_grant),
        .o_grant_onehot (w_pick_onehot),
        .o_grant_idx    (w_pick_idx),
        .o_any          (w_pick_any)
    );

    // Select the winner's byte from the flat data bus
    always_comb begin
        w_pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_onehot[i]) begin
                w_pick_data = bus.req_data_in[8*i +: 8];
            end
        end
    end

    // Ready only while idle and out of reset so a reset cycle never eats a byte
    assign w_grant   = (r_state == ST_IDLE) && w_pick_any && rst_n_in;
    // A done arriving on the last watchdog cycle takes priority over timeout
    assign w_timeout = (r_state == ST_WAIT) && !bus.tx_done_in &&
                       (r_wdog == c_CNT_LAST) && rst_n_in;

    assign bus.req_ready_out = w_grant ? w_pick_onehot : '0;
    assign bus.tx_data_out   = r_tx_data;
    assign bus.tx_start_out  = r_tx_start;
    assign bus.busy_out      = r_busy;
    assign bus.grant_id_out  = r_grant_id;
    assign bus.timeout_out   = w_timeout;

    // Arbiter FSM with watchdog, captured byte and registered status outputs
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state      <= ST_IDLE;
            r_last_grant <= c_LAST_RST;
            r_grant_id   <= '0;
            r_tx_data    <= '0;
            r_tx_start   <= 1'b0;
            r_busy       <= 1'b0;
            r_wdog       <= '0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_tx_data  <= w_pick_data;
                        r_grant_id <= w_pick_idx;
                        r_tx_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    r_wdog  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wdog != c_CNT_MAX) begin
                        r_wdog <= r_wdog + c_CNT_ONE;
                    end
                    // Done or watchdog expiry both release the UART; a timed
                    // out byte is dropped, not retried
                    if (bus.tx_done_in || (r_wdog == c_CNT_LAST)) begin
                        r_last_grant <= r_grant_id;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : uart_tx_arbiter
`default_nettype wire
